// File: rtl/accum_table_pkg.sv
// Shared definitions for the accumulator table: default geometry, derived sizes,
// sequencer state encoding and the tile-to-row address map.
package accum_table_pkg;

  localparam int unsigned DefMaxOutRows = 128;
  localparam int unsigned DefMaxOutCols = 128;
  localparam int unsigned DefSysArrRows = 16;
  localparam int unsigned DefSysArrCols = 16;
  localparam int unsigned DefMaxKPasses = 16;

  localparam int unsigned NRT   = DefMaxOutRows / DefSysArrRows;
  localparam int unsigned NCT   = DefMaxOutCols / DefSysArrCols;
  localparam int unsigned DEPTH = DefMaxOutRows * NCT;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Each column tile owns a contiguous block of out_rows table rows.
  function automatic int unsigned tile_addr(input int unsigned col_tile,
                                            input int unsigned row_tile,
                                            input int unsigned sub_row,
                                            input logic        reverse,
                                            input int unsigned out_rows,
                                            input int unsigned arr_rows);
    int unsigned off;
    off = reverse ? (arr_rows - 1 - sub_row) : sub_row;
    return col_tile * out_rows + row_tile * arr_rows + off;
  endfunction

endpackage

// File: rtl/accum_wrap_counter.sv
// Up-counter that wraps to zero at a runtime limit; wrap flags the limit value.
module accum_wrap_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= wrap ? '0 : count_q + 1'b1;
    end
  end

  assign wrap  = (count_q == limit);
  assign count = count_q;

endmodule

// File: rtl/accum_table_addr_seq.sv
// Walks every row of every output tile over K passes, emitting one accumulator
// table address per valid/ready transfer. All outputs come straight from flops.
module accum_table_addr_seq
  import accum_table_pkg::*;
#(
  parameter int unsigned MAX_OUT_ROWS = DefMaxOutRows,
  parameter int unsigned MAX_OUT_COLS = DefMaxOutCols,
  parameter int unsigned SYS_ARR_ROWS = DefSysArrRows,
  parameter int unsigned SYS_ARR_COLS = DefSysArrCols,
  parameter int unsigned MAX_K_PASSES = DefMaxKPasses,
  localparam int unsigned RW    = $clog2(MAX_OUT_ROWS / SYS_ARR_ROWS),
  localparam int unsigned CW    = $clog2(MAX_OUT_COLS / SYS_ARR_COLS),
  localparam int unsigned KW    = $clog2(MAX_K_PASSES),
  localparam int unsigned AddrW = $clog2(MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS))
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [RW-1:0]    cfg_row_tiles_m1,
  input  logic [CW-1:0]    cfg_col_tiles_m1,
  input  logic [KW-1:0]    cfg_k_passes_m1,
  input  logic             cfg_reverse,
  output logic             addr_valid,
  input  logic             addr_ready,
  output logic [AddrW-1:0] addr,
  output logic             accum,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SW = $clog2(SYS_ARR_ROWS);
  localparam logic [SW-1:0] SubLim = SW'(SYS_ARR_ROWS - 1);

  state_e state_q, state_d;

  logic [RW-1:0] row_lim_q;
  logic [CW-1:0] col_lim_q;
  logic [KW-1:0] k_lim_q;
  logic          rev_q;

  logic             valid_q, valid_d, accum_q, accum_d, last_q, last_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [AddrW-1:0] addr_q, addr_d;

  logic [SW-1:0] sub_cnt, sub_nxt;
  logic [RW-1:0] row_cnt, row_nxt;
  logic [CW-1:0] col_cnt, col_nxt;
  logic [KW-1:0] k_cnt, k_nxt;
  logic          sub_wrap, row_wrap, col_wrap, k_wrap;
  logic          start_ok, abort_ok, xfer, clr;
  logic          en_sub, en_row, en_col, en_k, last_nxt;

  assign start_ok = (state_q == StIdle) && start;
  assign abort_ok = (state_q != StIdle) && abort;
  assign xfer     = valid_q && addr_ready;
  assign clr      = start_ok || abort_ok;

  assign en_sub = xfer;
  assign en_row = en_sub && sub_wrap;
  assign en_col = en_row && row_wrap;
  assign en_k   = en_col && col_wrap;

  accum_wrap_counter #(.W(SW)) u_sub (
    .clk(clk), .rst_n(rst_n), .en(en_sub), .clr(clr), .limit(SubLim),
    .count(sub_cnt), .wrap(sub_wrap)
  );
  accum_wrap_counter #(.W(RW)) u_row (
    .clk(clk), .rst_n(rst_n), .en(en_row), .clr(clr), .limit(row_lim_q),
    .count(row_cnt), .wrap(row_wrap)
  );
  accum_wrap_counter #(.W(CW)) u_col (
    .clk(clk), .rst_n(rst_n), .en(en_col), .clr(clr), .limit(col_lim_q),
    .count(col_cnt), .wrap(col_wrap)
  );
  accum_wrap_counter #(.W(KW)) u_k (
    .clk(clk), .rst_n(rst_n), .en(en_k), .clr(clr), .limit(k_lim_q),
    .count(k_cnt), .wrap(k_wrap)
  );

  // Counter values after this edge, so the output flops can load the next address.
  assign sub_nxt = en_sub ? (sub_wrap ? '0 : sub_cnt + 1'b1) : sub_cnt;
  assign row_nxt = en_row ? (row_wrap ? '0 : row_cnt + 1'b1) : row_cnt;
  assign col_nxt = en_col ? (col_wrap ? '0 : col_cnt + 1'b1) : col_cnt;
  assign k_nxt   = en_k   ? (k_wrap   ? '0 : k_cnt   + 1'b1) : k_cnt;
  assign last_nxt = (sub_nxt == SubLim) && (row_nxt == row_lim_q) &&
                    (col_nxt == col_lim_q) && (k_nxt == k_lim_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      addr_q  <= '0;
      accum_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      accum_q <= accum_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_lim_q <= '0;
      col_lim_q <= '0;
      k_lim_q   <= '0;
      rev_q     <= 1'b0;
    end else if (start_ok) begin
      row_lim_q <= cfg_row_tiles_m1;
      col_lim_q <= cfg_col_tiles_m1;
      k_lim_q   <= cfg_k_passes_m1;
      rev_q     <= cfg_reverse;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun: begin
        if (abort) state_d = StIdle;
        else if (xfer && last_q) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    accum_d = accum_q;
    last_d  = last_q;
    done_d  = (state_d == StDone);
    busy_d  = (state_d == StRun);
    if (start_ok) begin
      valid_d = 1'b1;
      addr_d  = AddrW'(tile_addr(0, 0, 0, cfg_reverse, MAX_OUT_ROWS, SYS_ARR_ROWS));
      accum_d = 1'b0;
      last_d  = 1'b0;
    end else if (abort_ok || (xfer && last_q)) begin
      valid_d = 1'b0;
      addr_d  = '0;
      accum_d = 1'b0;
      last_d  = 1'b0;
    end else if (xfer) begin
      addr_d  = AddrW'(tile_addr(32'(col_nxt), 32'(row_nxt), 32'(sub_nxt), rev_q,
                                 MAX_OUT_ROWS, SYS_ARR_ROWS));
      accum_d = (k_nxt != '0);
      last_d  = last_nxt;
    end
  end

  assign addr_valid = valid_q;
  assign addr       = addr_q;
  assign accum      = accum_q;
  assign last       = last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
